// File: rtl/bmp180_i2c_target_pkg.sv
// Shared BMP180 register map constants, command codes and target FSM encoding.
package bmp180_i2c_target_pkg;

    localparam logic [7:0] REG_CHIP_ID     = 8'hD0;
    localparam logic [7:0] REG_CALIB_FIRST = 8'hAA;
    localparam logic [7:0] REG_CALIB_LAST  = 8'hBF;
    localparam logic [7:0] REG_CTRL_MEAS   = 8'hF4;
    localparam logic [7:0] REG_OUT_MSB     = 8'hF6;
    localparam logic [7:0] REG_OUT_LSB     = 8'hF7;
    localparam logic [7:0] REG_OUT_XLSB    = 8'hF8;

    localparam logic [7:0] CMD_TEMP  = 8'h2E;
    localparam logic [7:0] CMD_PRESS = 8'h34;
    localparam logic [7:0] SCO_MASK  = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_WAIT_STOP
    } i2c_state_t;

    // Byte idx of the calibration image; idx 0 is register 0xAA (image MSB).
    function automatic logic [7:0] calib_byte(input logic [175:0] img, input logic [4:0] idx);
        return img[175 - 8*idx -: 8];
    endfunction

endpackage

// File: rtl/bmp180_i2c_target_if.sv
// Raw I2C pin bundle between a bus master and the BMP180 target (open-drain SDA).
interface bmp180_i2c_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/bmp180_i2c_target_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge and START/STOP strobes.
module bmp180_i2c_target_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;
    logic       scl;

    // Idle bus is high, so reset to 1 to avoid phantom edges on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_pin};
            sda_sync <= {sda_sync[0], sda_pin};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/bmp180_i2c_target.sv
// BMP180 I2C target model: register map, pointer, byte FSM and timed conversion.
module bmp180_i2c_target
    import bmp180_i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADR      = 7'h77,
    parameter logic [7:0]  CHIP_ID      = 8'h55,
    parameter logic [15:0] T_CONV_TEMP  = 16'd4500,
    parameter logic [15:0] T_CONV_PRESS = 16'd4500
) (
    input  logic                      clk,
    input  logic                      reset,
    bmp180_i2c_target_if.slave        bus,
    input  logic [175:0]              calib,
    input  logic [15:0]               ut_raw,
    input  logic [23:0]               up_raw,
    output logic [7:0]                ctrl_meas,
    output logic                      conv_done
);

    logic       sda, scl_rise, scl_fall, start, stop;
    i2c_state_t state;
    logic [3:0] bit_cnt;
    logic [7:0] shift, ptr, rd_byte, rx_byte;
    logic       sda_drive;
    logic [7:0] res_msb, res_lsb, res_xlsb;
    logic [15:0] conv_cnt;
    logic       conv_press;
    logic       ctrl_wr;

    bmp180_i2c_target_line_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_pin  (bus.scl_in),
        .sda_pin  (bus.sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign bus.sda_oe = sda_drive;
    assign rx_byte    = {shift[6:0], sda};
    assign ctrl_wr    = (state == ST_WDATA) && scl_rise && (bit_cnt == 4'd7) &&
                        (ptr == REG_CTRL_MEAS);

    always_comb begin
        rd_byte = '0;
        case (ptr) inside
            REG_CHIP_ID:                       rd_byte = CHIP_ID;
            [REG_CALIB_FIRST:REG_CALIB_LAST]:  rd_byte = calib_byte(calib, 5'(ptr - REG_CALIB_FIRST));
            REG_CTRL_MEAS:                     rd_byte = ctrl_meas;
            REG_OUT_MSB:                       rd_byte = res_msb;
            REG_OUT_LSB:                       rd_byte = res_lsb;
            REG_OUT_XLSB:                      rd_byte = res_xlsb;
            default:                           rd_byte = '0;
        endcase
    end

    // ACK states use sda_drive as the phase: first SCL fall pulls low, second releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            sda_drive <= 1'b0;
        end else if (start) begin
            state     <= ST_ADDR;
            bit_cnt   <= '0;
            sda_drive <= 1'b0;
        end else if (stop) begin
            state     <= ST_IDLE;
            sda_drive <= 1'b0;
        end else begin
            case (state)
                ST_ADDR: if (scl_rise) begin
                    shift   <= rx_byte;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        state   <= (rx_byte[7:1] == DEV_ADR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                    end
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!sda_drive) begin
                        sda_drive <= 1'b1;
                    end else if (shift[0]) begin
                        shift     <= rd_byte;
                        ptr       <= ptr + 8'd1;
                        sda_drive <= ~rd_byte[7];
                        bit_cnt   <= '0;
                        state     <= ST_RDATA;
                    end else begin
                        sda_drive <= 1'b0;
                        state     <= ST_PTR;
                    end
                end
                ST_PTR: if (scl_rise) begin
                    shift   <= rx_byte;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        ptr     <= rx_byte;
                        bit_cnt <= '0;
                        state   <= ST_PTR_ACK;
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    shift   <= rx_byte;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        ptr     <= ptr + 8'd1;
                        bit_cnt <= '0;
                        state   <= ST_WDATA_ACK;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    sda_drive <= ~sda_drive;
                    if (sda_drive) state <= ST_WDATA;
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_drive <= 1'b0;
                            state     <= ST_RACK;
                        end else begin
                            shift     <= {shift[6:0], 1'b0};
                            sda_drive <= ~shift[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda) state <= ST_WAIT_STOP;
                        else     bit_cnt <= '0;
                    end else if (scl_fall && bit_cnt == 4'd0) begin
                        shift     <= rd_byte;
                        ptr       <= ptr + 8'd1;
                        sda_drive <= ~rd_byte[7];
                        state     <= ST_RDATA;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_meas  <= '0;
            conv_cnt   <= '0;
            conv_press <= 1'b0;
            conv_done  <= 1'b0;
            res_msb    <= '0;
            res_lsb    <= '0;
            res_xlsb   <= '0;
        end else begin
            conv_done <= 1'b0;
            if (ctrl_wr) begin
                if (rx_byte[4:0] == CMD_TEMP[4:0]) begin
                    ctrl_meas  <= rx_byte | SCO_MASK;
                    conv_cnt   <= T_CONV_TEMP;
                    conv_press <= 1'b0;
                end else if (rx_byte[4:0] == CMD_PRESS[4:0]) begin
                    ctrl_meas  <= rx_byte | SCO_MASK;
                    conv_cnt   <= T_CONV_PRESS;
                    conv_press <= 1'b1;
                end else begin
                    ctrl_meas  <= rx_byte & ~SCO_MASK;
                end
            end else if ((ctrl_meas & SCO_MASK) != '0) begin
                conv_cnt <= conv_cnt - 16'd1;
                if (conv_cnt == 16'd1) begin
                    ctrl_meas <= ctrl_meas & ~SCO_MASK;
                    conv_done <= 1'b1;
                    if (conv_press) {res_msb, res_lsb, res_xlsb} <= up_raw;
                    else            {res_msb, res_lsb, res_xlsb} <= {ut_raw, 8'h00};
                end
            end
        end
    end

endmodule
